// File: rtl/mcs4_pkg.sv
// mcs4_pkg: shared MCS-4 timing defaults and run-state encoding. Rev 1.0
`default_nettype none

package mcs4_pkg;

  localparam int MCS4_PERIOD     = 68;
  localparam int MCS4_PHI1_WIDTH = 19;
  localparam int MCS4_PHI2_DELAY = 27;
  localparam int MCS4_PHI2_WIDTH = 19;
  localparam int MCS4_POC_CYCLES = 64;

  typedef enum logic [1:0] {
    RS_RUN      = 2'd0,
    RS_STOPPING = 2'd1,
    RS_STOPPED  = 2'd2,
    RS_STEP     = 2'd3
  } run_state_e;

endpackage

`default_nettype wire

// File: rtl/mcs4_sync2.sv
// mcs4_sync2: generic two-flop synchronizer with async active-low reset. Rev 1.0
`default_nettype none

module mcs4_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/mcs4_clockgen.sv
// mcs4_clockgen: MCS-4 two-phase clocks, power-on clear and stop/step control. Rev 1.0
`default_nettype none

module mcs4_clockgen
  import mcs4_pkg::*;
#(
  parameter int PERIOD     = MCS4_PERIOD,
  parameter int PHI1_WIDTH = MCS4_PHI1_WIDTH,
  parameter int PHI2_DELAY = MCS4_PHI2_DELAY,
  parameter int PHI2_WIDTH = MCS4_PHI2_WIDTH,
  parameter int POC_CYCLES = MCS4_POC_CYCLES
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic ext_reset_pad,
  input  logic clk_stop,
  input  logic step,
  output logic clk1_pad,
  output logic clk2_pad,
  output logic poc_pad,
  output logic cycle_strobe,
  output logic stopped
);

  localparam int CW = $clog2(PERIOD);
  localparam int PW = $clog2(POC_CYCLES + 1);

  localparam logic [CW-1:0] C_LAST    = CW'(PERIOD - 1);
  localparam logic [CW-1:0] C_PHI1_HI = CW'(PHI1_WIDTH);
  localparam logic [CW-1:0] C_PHI2_LO = CW'(PHI2_DELAY);
  localparam logic [CW-1:0] C_PHI2_HI = CW'(PHI2_DELAY + PHI2_WIDTH);
  localparam logic [PW-1:0] C_POC     = PW'(POC_CYCLES);

  generate
    if (PHI1_WIDTH < 1 || PHI2_WIDTH < 1) begin : g_chk_width
      $error("mcs4_clockgen: phase widths must be at least 1");
    end
    if (PHI1_WIDTH >= PHI2_DELAY) begin : g_chk_phi1
      $error("mcs4_clockgen: PHI1_WIDTH must be less than PHI2_DELAY");
    end
    if (PHI2_DELAY + PHI2_WIDTH >= PERIOD) begin : g_chk_phi2
      $error("mcs4_clockgen: PHI2_DELAY + PHI2_WIDTH must be less than PERIOD");
    end
  endgenerate

  logic            ext_rst_s;
  run_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   poc_cnt_q, poc_cnt_d;
  logic            poc_armed_q, poc_armed_d;
  logic            clk1_q, clk2_q, strobe_q, poc_q, stopped_q;
  logic            cnt_last;
  logic [CW-1:0]   cnt_inc;
  logic            strobe_d;

  mcs4_sync2 #(.WIDTH(1)) u_ext_sync (
    .clk_i  (sysclk),
    .rst_ni (reset_n),
    .d_i    (ext_reset_pad),
    .q_o    (ext_rst_s)
  );

  assign cnt_last = (cnt_q == C_LAST);
  assign cnt_inc  = cnt_last ? '0 : cnt_q + 1'b1;

  // A stop holds cnt at its last value so the decode below yields both clocks low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RS_RUN: begin
        cnt_d = cnt_inc;
        if (clk_stop && !poc_q) state_d = RS_STOPPING;
      end
      RS_STOPPING: begin
        if (!clk_stop) begin
          state_d = RS_RUN;
          cnt_d   = cnt_inc;
        end else if (cnt_last) begin
          state_d = RS_STOPPED;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RS_STOPPED: begin
        if (step) begin
          state_d = RS_STEP;
          cnt_d   = '0;
        end else if (!clk_stop) begin
          state_d = RS_RUN;
          cnt_d   = '0;
        end
      end
      RS_STEP: begin
        if (cnt_last && clk_stop) begin
          state_d = RS_STOPPED;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_last) state_d = RS_RUN;
        end
      end
      default: begin
        state_d = RS_RUN;
        cnt_d   = cnt_inc;
      end
    endcase
  end

  assign strobe_d = (cnt_d == '0);

  // The strobe opening the first period only arms the counter, so POC spans full periods.
  always_comb begin
    poc_cnt_d   = poc_cnt_q;
    poc_armed_d = poc_armed_q;
    if (ext_rst_s) begin
      poc_cnt_d   = C_POC;
      poc_armed_d = 1'b0;
    end else if (strobe_d) begin
      if (!poc_armed_q) begin
        poc_armed_d = 1'b1;
      end else if (poc_cnt_q != '0) begin
        poc_cnt_d = poc_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RS_RUN;
      cnt_q       <= C_LAST;
      poc_cnt_q   <= C_POC;
      poc_armed_q <= 1'b0;
      clk1_q      <= 1'b0;
      clk2_q      <= 1'b0;
      strobe_q    <= 1'b0;
      poc_q       <= 1'b1;
      stopped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      poc_cnt_q   <= poc_cnt_d;
      poc_armed_q <= poc_armed_d;
      clk1_q      <= (cnt_d < C_PHI1_HI);
      clk2_q      <= (cnt_d >= C_PHI2_LO) && (cnt_d < C_PHI2_HI);
      strobe_q    <= strobe_d;
      poc_q       <= (poc_cnt_d != '0);
      stopped_q   <= (state_d == RS_STOPPED);
    end
  end

  assign clk1_pad     = clk1_q;
  assign clk2_pad     = clk2_q;
  assign cycle_strobe = strobe_q;
  assign poc_pad      = poc_q;
  assign stopped      = stopped_q;

endmodule

`default_nettype wire
